// File: rtl/clk_div_pkg.sv
// Shared types, reset defaults and helpers for the programmable clock divider bank.
package clk_div_pkg;

    localparam int unsigned WIDTH = 28;
    localparam int unsigned NCH   = 2;

    typedef logic [WIDTH-1:0] cnt_t;

    localparam cnt_t DEF_DIV  = cnt_t'(2);
    localparam cnt_t DEF_DUTY = cnt_t'(1);

    // High phase of the divided clock: first `duty` counts of each period.
    function automatic logic duty_high(input cnt_t cnt, input cnt_t duty);
        return cnt < duty;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow divisor/duty registers and
// registered clk_out/tick outputs. Shadow values only take effect at a period
// boundary, on sync, while disabled, or while stopped (div_act == 0).
module clk_div_chan #(
    parameter int unsigned     WIDTH    = clk_div_pkg::WIDTH,
    parameter logic [WIDTH-1:0] DEF_DIV  = WIDTH'(clk_div_pkg::DEF_DIV),
    parameter logic [WIDTH-1:0] DEF_DUTY = WIDTH'(clk_div_pkg::DEF_DUTY)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] duty_in,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);
    import clk_div_pkg::*;

    logic [WIDTH-1:0] cnt,       cnt_n;
    logic [WIDTH-1:0] div_act,   div_act_n;
    logic [WIDTH-1:0] duty_act,  duty_act_n;
    logic [WIDTH-1:0] div_pend,  div_pend_n;
    logic [WIDTH-1:0] duty_pend, duty_pend_n;
    logic             pend,      pend_n;
    logic             clk_out_n, tick_n;
    logic [WIDTH-1:0] eff_div,   eff_duty;
    logic             eff_pend,  apply_now;

    // A load on the same edge as an apply point is applied directly (last write wins).
    always_comb begin
        cnt_n       = cnt;
        div_act_n   = div_act;
        duty_act_n  = duty_act;
        div_pend_n  = div_pend;
        duty_pend_n = duty_pend;
        pend_n      = pend;
        clk_out_n   = 1'b0;
        tick_n      = 1'b0;
        apply_now   = 1'b0;
        eff_div     = load ? div_in  : div_pend;
        eff_duty    = load ? duty_in : duty_pend;
        eff_pend    = load | pend;

        if (load) begin
            div_pend_n  = div_in;
            duty_pend_n = duty_in;
            pend_n      = 1'b1;
        end

        if (sync || !en) begin
            cnt_n     = '0;
            apply_now = 1'b1;
        end else if (div_act == '0) begin
            // Stopped channel: a value latched on an earlier edge applies now.
            cnt_n     = '0;
            apply_now = pend && !load;
        end else begin
            clk_out_n = duty_high(cnt_t'(cnt), cnt_t'(duty_act));
            tick_n    = (cnt == '0);
            if (cnt == div_act - WIDTH'(1)) begin
                cnt_n     = '0;
                apply_now = 1'b1;
            end else begin
                cnt_n = cnt + WIDTH'(1);
            end
        end

        if (apply_now && eff_pend) begin
            div_act_n  = eff_div;
            duty_act_n = eff_duty;
            pend_n     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt       <= '0;
            div_act   <= DEF_DIV;
            duty_act  <= DEF_DUTY;
            div_pend  <= DEF_DIV;
            duty_pend <= DEF_DUTY;
            pend      <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            div_act   <= div_act_n;
            duty_act  <= duty_act_n;
            div_pend  <= div_pend_n;
            duty_pend <= duty_pend_n;
            pend      <= pend_n;
            clk_out   <= clk_out_n;
            tick      <= tick_n;
        end
    end

    assign busy = pend;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock dividers sharing sync and load data.
module clk_div_bank #(
    parameter int unsigned      WIDTH    = clk_div_pkg::WIDTH,
    parameter int unsigned      NCH      = clk_div_pkg::NCH,
    parameter logic [WIDTH-1:0] DEF_DIV  = WIDTH'(clk_div_pkg::DEF_DIV),
    parameter logic [WIDTH-1:0] DEF_DUTY = WIDTH'(clk_div_pkg::DEF_DUTY)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic [NCH-1:0]   load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] duty_in,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
);
    import clk_div_pkg::*;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH    (WIDTH),
            .DEF_DIV  (DEF_DIV),
            .DEF_DUTY (DEF_DUTY)
        ) u_chan (
            .clk     (clk),
            .RESET   (RESET),
            .en      (en[i]),
            .sync    (sync),
            .load    (load[i]),
            .div_in  (div_in),
            .duty_in (duty_in),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed scoreboard bench for clk_div_bank: stimulus queues per-cycle expected
// outputs, a monitor compares them just after every rising edge.
module tb_clk_div_bank;

    localparam int unsigned WIDTH = 28;
    localparam int unsigned NCH   = 2;

    logic             clk = 1'b0;
    logic             RESET;
    logic [NCH-1:0]   en;
    logic             sync;
    logic [NCH-1:0]   load;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] duty_in;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   busy;

    clk_div_bank dut (
        .clk     (clk),
        .RESET   (RESET),
        .en      (en),
        .sync    (sync),
        .load    (load),
        .div_in  (div_in),
        .duty_in (duty_in),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         idx;
        logic [1:0] m;
        logic [1:0] co;
        logic [1:0] tk;
        logic [1:0] bz;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t e;

    // Monitor: one queued expectation per rising edge, masked per channel.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int ch = 0; ch < NCH; ch++) begin
                if (e.m[ch]) begin
                    checks++;
                    if ({clk_out[ch], tick[ch], busy[ch]} !== {e.co[ch], e.tk[ch], e.bz[ch]}) begin
                        errors++;
                        $display("FAIL %s[%0d] ch%0d: clk_out/tick/busy got %b%b%b expected %b%b%b",
                                 e.name, e.idx, ch, clk_out[ch], tick[ch], busy[ch],
                                 e.co[ch], e.tk[ch], e.bz[ch]);
                    end
                end
            end
        end
    end

    // n cycles with load/sync pulsed on the first; expected bit vectors MSB-first.
    task automatic run(input string nm, input int n, input logic [1:0] m,
                       input logic [1:0] ld, input logic sy,
                       input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] dt,
                       input logic [31:0] co0, input logic [31:0] tk0, input logic [31:0] bz0,
                       input logic [31:0] co1, input logic [31:0] tk1, input logic [31:0] bz1);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            load    = (i == 0) ? ld : 2'b00;
            sync    = (i == 0) ? sy : 1'b0;
            div_in  = dv;
            duty_in = dt;
            x.name  = nm;
            x.idx   = i;
            x.m     = m;
            x.co    = {co1[n-1-i], co0[n-1-i]};
            x.tk    = {tk1[n-1-i], tk0[n-1-i]};
            x.bz    = {bz1[n-1-i], bz0[n-1-i]};
            q.push_back(x);
            @(negedge clk);
        end
        load = 2'b00;
        sync = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; en = 2'b00; sync = 1'b0; load = 2'b00; div_in = '0; duty_in = '0;
        run("reset", 3, 2'b11, 2'b00, 1'b0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

        RESET = 1'b0; en = 2'b11;
        run("dflt", 6, 2'b11, 2'b00, 1'b0, 0, 0,
            6'b101010, 6'b101010, 6'b000000, 6'b101010, 6'b101010, 6'b000000);

        run("div5", 12, 2'b11, 2'b01, 1'b0, 5, 2,
            12'b101100011000, 12'b101000010000, 12'b100000000000,
            12'b101010101010, 12'b101010101010, 12'b000000000000);

        run("div10", 6, 2'b10, 2'b10, 1'b0, 10, 5,
            0, 0, 0, 6'b101111, 6'b101000, 6'b100000);
        run("glitch", 12, 2'b10, 2'b10, 1'b0, 3, 1,
            0, 0, 0, 12'b100000100100, 12'b000000100100, 12'b111110000000);

        run("duty0", 8, 2'b01, 2'b01, 1'b0, 4, 0,
            8'b00000000, 8'b00100010, 8'b10000000, 0, 0, 0);
        run("duty7", 8, 2'b01, 2'b01, 1'b0, 4, 7,
            8'b00111111, 8'b00100010, 8'b10000000, 0, 0, 0);

        run("div0", 5, 2'b01, 2'b01, 1'b0, 0, 3,
            5'b11000, 5'b00000, 5'b10000, 0, 0, 0);
        run("ld_stop", 1, 2'b01, 2'b01, 1'b0, 6, 3, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        en = 2'b10;
        run("en_off", 2, 2'b01, 2'b00, 1'b0, 6, 3, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        en = 2'b11;
        run("reen", 7, 2'b01, 2'b00, 1'b0, 6, 3,
            7'b1110001, 7'b1000001, 7'b0000000, 0, 0, 0);

        run("ld1", 1, 2'b00, 2'b10, 1'b0, 8, 4, 0, 0, 0, 0, 0, 0);
        run("ld0", 1, 2'b00, 2'b01, 1'b0, 4, 2, 0, 0, 0, 0, 0, 0);
        run("settle", 6, 2'b00, 2'b00, 1'b0, 4, 2, 0, 0, 0, 0, 0, 0);
        run("sync", 6, 2'b11, 2'b00, 1'b1, 4, 2,
            6'b011001, 6'b010001, 6'b000000, 6'b011110, 6'b010000, 6'b000000);
        run("pre_rst", 1, 2'b11, 2'b00, 1'b0, 4, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        RESET = 1'b1;
        run("mid_rst", 2, 2'b11, 2'b00, 1'b0, 4, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        RESET = 1'b0;
        run("rst_dflt", 3, 2'b11, 2'b00, 1'b0, 4, 2,
            3'b101, 3'b101, 3'b000, 3'b101, 3'b101, 3'b000);

        run("ld_wrap", 5, 2'b11, 2'b11, 1'b0, 3, 1,
            5'b01001, 5'b01001, 5'b00000, 5'b01001, 5'b01001, 5'b00000);

        run("div1", 4, 2'b01, 2'b01, 1'b0, 1, 1,
            4'b0011, 4'b0011, 4'b1000, 0, 0, 0);

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
